// File: rtl/exception_unit_pkg.sv
// exceptionGroup: shared types and constants for the exception unit.
//   state_e       - handler state (IDLE / ACTIVE)
//   NUM_SOURCES   - total pending sources (8 internal + 8 external)
//   IRQ_BASE      - index of the first external interrupt source
//   VECTOR_STRIDE - byte distance between vector table entries
//   lowest_index  - fixed-priority pick, lowest set bit wins
package exceptionGroup;

  localparam int NUM_SOURCES   = 16;
  localparam int IRQ_BASE      = 8;
  localparam int VECTOR_STRIDE = 4;
  localparam int NUM_IRQ       = NUM_SOURCES - IRQ_BASE;
  localparam int IDX_W         = $clog2(NUM_SOURCES);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  function automatic logic [IDX_W-1:0] lowest_index(input logic [NUM_SOURCES-1:0] bits);
    logic [IDX_W-1:0] idx;
    idx = '0;
    // Scan downward so the last hit is the lowest index.
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (bits[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/exception_unit_if.sv
// exception_unit_if: core/system-side bundle of the exception unit.
//   master - core and system register block (drives requests, irq, config, ack/return)
//   slave  - the exception unit (drives pending/cause/vector/status)
interface exception_unit_if;
  import exceptionGroup::*;

  logic [15:0] exceptionRequest;
  logic [7:0]  irq;
  logic        interruptEnable;
  logic [15:0] exceptionMask;
  logic [31:0] isrBaseAddress;
  logic        exceptionAck;
  logic        exceptionReturn;
  logic        exceptionPending;
  logic [4:0]  cause;
  logic [31:0] vectorAddress;
  logic        inException;
  logic [15:0] pendingBits;

  modport master (
    output exceptionRequest, irq, interruptEnable, exceptionMask, isrBaseAddress,
           exceptionAck, exceptionReturn,
    input  exceptionPending, cause, vectorAddress, inException, pendingBits
  );

  modport slave (
    input  exceptionRequest, irq, interruptEnable, exceptionMask, isrBaseAddress,
           exceptionAck, exceptionReturn,
    output exceptionPending, cause, vectorAddress, inException, pendingBits
  );

endinterface

// File: rtl/exception_unit_irq_sync.sv
// irq_sync: per-line 2-flop synchronizer plus rising-edge detector.
//   clk, reset - system clock, async active-high reset
//   irq_i      - asynchronous interrupt levels
//   rise_o     - one-cycle pulse per line on a synchronized 0->1 transition
module irq_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] irq_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [2:0]       arm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      meta_q <= irq_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      arm_q  <= {arm_q[1:0], 1'b1};
    end
  end

  // The flops restart at 0, so a line already high at reset release would look
  // like a rising edge. Edges are only reported once prev_q holds a genuine
  // post-reset sample (three clocks after release).
  assign rise_o = arm_q[2] ? (sync_q & ~prev_q) : '0;

endmodule

// File: rtl/exception_unit.sv
// exception_unit: collects internal exception pulses and external interrupt
// edges into sticky pending bits, arbitrates by fixed priority (lowest index)
// and hands one exception at a time to the core.
//   clk, reset - system clock, async active-high reset
//   bus        - exception_unit_if.slave: requests, irq, enable, mask, vector
//                base, ack/return in; pending, cause, vector, status out
module exception_unit
  import exceptionGroup::*;
(
  input  logic              clk,
  input  logic              reset,
  exception_unit_if.slave   bus
);

  state_e                 state_q, state_d;
  logic [NUM_SOURCES-1:0] pend_q, pend_d;
  logic [4:0]             cause_q, cause_d;
  logic [31:0]            vec_q, vec_d;

  logic [NUM_IRQ-1:0]     irq_rise;
  logic [NUM_SOURCES-1:0] set_vec;
  logic [NUM_SOURCES-1:0] eligible;
  logic [IDX_W-1:0]       win_idx;
  logic                   any_eligible;
  logic                   accept;

  irq_sync #(.WIDTH(NUM_IRQ)) u_irq_sync (
    .clk    (clk),
    .reset  (reset),
    .irq_i  (bus.irq),
    .rise_o (irq_rise)
  );

  assign set_vec      = {irq_rise, bus.exceptionRequest[IRQ_BASE-1:0]};
  assign eligible     = pend_q & ~bus.exceptionMask
                        & {{NUM_IRQ{bus.interruptEnable}}, {IRQ_BASE{1'b1}}};
  assign any_eligible = |eligible;
  assign win_idx      = lowest_index(eligible);
  assign accept       = (state_q == IDLE) && any_eligible && bus.exceptionAck;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cause_d = cause_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d         = ACTIVE;
          cause_d         = {1'b0, win_idx};
          vec_d           = bus.isrBaseAddress + 32'(win_idx) * 32'(VECTOR_STRIDE);
          pend_d[win_idx] = 1'b0;
        end
      end
      ACTIVE: begin
        if (bus.exceptionReturn) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Applied after the ack clear so a same-cycle re-request keeps the bit set.
    pend_d = pend_d | set_vec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      cause_q <= '0;
      vec_q   <= 32'd4;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cause_q <= cause_d;
      vec_q   <= vec_d;
    end
  end

  assign bus.exceptionPending = (state_q == IDLE) && any_eligible;
  assign bus.cause            = cause_q;
  assign bus.vectorAddress    = vec_q;
  assign bus.inException      = (state_q == ACTIVE);
  assign bus.pendingBits      = pend_q;

endmodule

// File: tb/tb_exception_unit.sv
module tb_exception_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  exception_unit_if bus();

  exception_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.exceptionRequest = '0;
    bus.exceptionAck     = 1'b0;
    bus.exceptionReturn  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    bus.exceptionRequest = '0;
    bus.irq              = '0;
    bus.interruptEnable  = 1'b0;
    bus.exceptionMask    = '0;
    bus.isrBaseAddress   = 32'h100;
    bus.exceptionAck     = 1'b0;
    bus.exceptionReturn  = 1'b0;
    do_reset();
    checks++;
    if (bus.pendingBits !== 16'h0) begin
      errors++; $display("FAIL reset_pending: got %h expected 0000", bus.pendingBits);
    end
    checks++;
    if ({bus.exceptionPending, bus.inException} !== 2'b00) begin
      errors++; $display("FAIL reset_status: got pend=%b inExc=%b expected 0 0",
                         bus.exceptionPending, bus.inException);
    end
    checks++;
    if (bus.cause !== 5'd0 || bus.vectorAddress !== 32'd4) begin
      errors++; $display("FAIL reset_regs: got cause=%0d vec=%h expected 0 00000004",
                         bus.cause, bus.vectorAddress);
    end
  endtask

  task automatic test_basic_dispatch();
    bus.isrBaseAddress = 32'h100;
    bus.exceptionRequest = 16'h0008;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.exceptionPending !== 1'b1 || bus.pendingBits !== 16'h0008) begin
      errors++; $display("FAIL basic_pending: got pend=%b bits=%h expected 1 0008",
                         bus.exceptionPending, bus.pendingBits);
    end
    bus.exceptionAck = 1'b1;
    tick();
    bus.exceptionAck = 1'b0;
    #1;
    checks++;
    if (bus.cause !== 5'd3 || bus.vectorAddress !== 32'h10C || bus.inException !== 1'b1) begin
      errors++; $display("FAIL basic_dispatch: got cause=%0d vec=%h inExc=%b expected 3 0000010c 1",
                         bus.cause, bus.vectorAddress, bus.inException);
    end
    // Ack while active must not re-dispatch or change cause.
    bus.exceptionRequest = 16'h0002;
    tick();
    bus.exceptionRequest = 16'h0;
    bus.exceptionAck = 1'b1;
    tick();
    bus.exceptionAck = 1'b0;
    #1;
    checks++;
    if (bus.cause !== 5'd3 || bus.pendingBits !== 16'h0002 || bus.exceptionPending !== 1'b0) begin
      errors++; $display("FAIL active_ignore_ack: got cause=%0d bits=%h pend=%b expected 3 0002 0",
                         bus.cause, bus.pendingBits, bus.exceptionPending);
    end
    bus.exceptionReturn = 1'b1;
    tick();
    bus.exceptionReturn = 1'b0;
    #1;
    checks++;
    if (bus.inException !== 1'b0 || bus.exceptionPending !== 1'b1) begin
      errors++; $display("FAIL basic_return: got inExc=%b pend=%b expected 0 1",
                         bus.inException, bus.exceptionPending);
    end
    bus.exceptionAck = 1'b1;
    tick();
    bus.exceptionAck = 1'b0;
    bus.exceptionReturn = 1'b1;
    tick();
    bus.exceptionReturn = 1'b0;
  endtask

  task automatic test_irq_gating();
    bus.interruptEnable = 1'b0;
    bus.irq = 8'h02;
    tick(); tick();
    #1;
    checks++;
    if (bus.pendingBits[9] !== 1'b0) begin
      errors++; $display("FAIL irq_latency_early: got bit9=%b expected 0", bus.pendingBits[9]);
    end
    tick();
    #1;
    checks++;
    if (bus.pendingBits !== 16'h0200 || bus.exceptionPending !== 1'b0) begin
      errors++; $display("FAIL irq_gated: got bits=%h pend=%b expected 0200 0",
                         bus.pendingBits, bus.exceptionPending);
    end
    bus.interruptEnable = 1'b1;
    #1;
    checks++;
    if (bus.exceptionPending !== 1'b1) begin
      errors++; $display("FAIL irq_enabled: got pend=%b expected 1", bus.exceptionPending);
    end
    bus.exceptionAck = 1'b1;
    tick();
    bus.exceptionAck = 1'b0;
    #1;
    checks++;
    if (bus.cause !== 5'd9 || bus.vectorAddress !== 32'h124) begin
      errors++; $display("FAIL irq_dispatch: got cause=%0d vec=%h expected 9 00000124",
                         bus.cause, bus.vectorAddress);
    end
    bus.exceptionReturn = 1'b1;
    tick();
    bus.exceptionReturn = 1'b0;
    bus.irq = 8'h00;
    bus.interruptEnable = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_priority();
    bus.exceptionRequest = 16'h0024;
    tick();
    bus.exceptionRequest = 16'h0;
    bus.exceptionAck = 1'b1;
    tick();
    bus.exceptionAck = 1'b0;
    #1;
    checks++;
    if (bus.cause !== 5'd2 || bus.pendingBits !== 16'h0020) begin
      errors++; $display("FAIL priority_first: got cause=%0d bits=%h expected 2 0020",
                         bus.cause, bus.pendingBits);
    end
    bus.exceptionReturn = 1'b1;
    tick();
    bus.exceptionReturn = 1'b0;
    bus.exceptionAck = 1'b1;
    tick();
    bus.exceptionAck = 1'b0;
    #1;
    checks++;
    if (bus.cause !== 5'd5 || bus.vectorAddress !== 32'h114) begin
      errors++; $display("FAIL priority_second: got cause=%0d vec=%h expected 5 00000114",
                         bus.cause, bus.vectorAddress);
    end
    bus.exceptionReturn = 1'b1;
    tick();
    bus.exceptionReturn = 1'b0;
  endtask

  task automatic test_masking();
    bus.exceptionMask = 16'h0010;
    bus.exceptionRequest = 16'h0010;
    tick();
    bus.exceptionRequest = 16'h0;
    bus.exceptionAck = 1'b1;
    tick();
    bus.exceptionAck = 1'b0;
    #1;
    checks++;
    if (bus.exceptionPending !== 1'b0 || bus.pendingBits !== 16'h0010 || bus.inException !== 1'b0) begin
      errors++; $display("FAIL mask_gate: got pend=%b bits=%h inExc=%b expected 0 0010 0",
                         bus.exceptionPending, bus.pendingBits, bus.inException);
    end
    bus.exceptionMask = 16'h0;
    #1;
    checks++;
    if (bus.exceptionPending !== 1'b1) begin
      errors++; $display("FAIL mask_clear: got pend=%b expected 1", bus.exceptionPending);
    end
    bus.exceptionAck = 1'b1;
    tick();
    bus.exceptionAck = 1'b0;
    bus.exceptionReturn = 1'b1;
    tick();
    bus.exceptionReturn = 1'b0;
  endtask

  task automatic test_same_cycle();
    bus.exceptionRequest = 16'h0001;
    tick();
    bus.exceptionAck = 1'b1;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.pendingBits[0] !== 1'b1 || bus.inException !== 1'b1 || bus.cause !== 5'd0) begin
      errors++; $display("FAIL same_cycle: got bit0=%b inExc=%b cause=%0d expected 1 1 0",
                         bus.pendingBits[0], bus.inException, bus.cause);
    end
    bus.exceptionReturn = 1'b1;
    tick();
    bus.exceptionReturn = 1'b0;
    bus.exceptionAck = 1'b1;
    tick();
    bus.exceptionAck = 1'b0;
    bus.exceptionReturn = 1'b1;
    tick();
    bus.exceptionReturn = 1'b0;
    #1;
    checks++;
    if (bus.pendingBits !== 16'h0 || bus.inException !== 1'b0) begin
      errors++; $display("FAIL same_cycle_drain: got bits=%h inExc=%b expected 0000 0",
                         bus.pendingBits, bus.inException);
    end
  endtask

  task automatic test_reset_in_active();
    bus.exceptionRequest = 16'h0040;
    bus.isrBaseAddress = 32'h2000;
    tick();
    bus.exceptionRequest = 16'h0081;
    bus.exceptionAck = 1'b1;
    tick();
    idle_inputs();
    bus.interruptEnable = 1'b1;
    #2;
    reset = 1'b1;
    bus.irq = 8'hFF;
    #1;
    checks++;
    if (bus.inException !== 1'b0 || bus.pendingBits !== 16'h0 || bus.vectorAddress !== 32'd4
        || bus.cause !== 5'd0 || bus.exceptionPending !== 1'b0) begin
      errors++; $display("FAIL async_reset: got inExc=%b bits=%h vec=%h cause=%0d pend=%b expected 0 0000 00000004 0 0",
                         bus.inException, bus.pendingBits, bus.vectorAddress, bus.cause, bus.exceptionPending);
    end
    @(negedge clk);
    tick(); tick();
    reset = 1'b0;
    repeat (8) tick();
    #1;
    checks++;
    if (bus.pendingBits !== 16'h0 || bus.exceptionPending !== 1'b0) begin
      errors++; $display("FAIL irq_held_reset: got bits=%h pend=%b expected 0000 0",
                         bus.pendingBits, bus.exceptionPending);
    end
    bus.irq = 8'h00;
    repeat (4) tick();
    bus.irq = 8'h04;
    tick(); tick();
    tick();
    #1;
    checks++;
    if (bus.pendingBits !== 16'h0400) begin
      errors++; $display("FAIL irq_after_reset: got bits=%h expected 0400", bus.pendingBits);
    end
    bus.irq = 8'h00;
    bus.interruptEnable = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] mpend, elig, setv;
    logic        mact;
    logic [4:0]  mcause;
    logic [31:0] mvec;
    logic [7:0]  h0, h1, h2;
    int          w;
    idle_inputs();
    bus.irq = 8'h00;
    bus.exceptionMask = 16'h0;
    bus.interruptEnable = 1'b0;
    do_reset();
    mpend = '0; mact = 1'b0; mcause = '0; mvec = 32'd4;
    h0 = '0; h1 = '0; h2 = '0;
    for (int c = 0; c < 400; c++) begin
      bus.exceptionRequest = ($urandom_range(0, 3) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
      if ($urandom_range(0, 3) == 0) bus.irq = bus.irq ^ 8'($urandom);
      bus.exceptionMask   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      bus.interruptEnable = ($urandom_range(0, 3) != 0);
      bus.isrBaseAddress  = $urandom;
      bus.exceptionAck    = ($urandom_range(0, 1) == 1);
      bus.exceptionReturn = ($urandom_range(0, 3) == 0);
      #1;
      elig = mpend & ~bus.exceptionMask & (bus.interruptEnable ? 16'hFFFF : 16'h00FF);
      checks++;
      if (bus.exceptionPending !== (!mact && elig != 16'h0)) begin
        errors++; $display("FAIL rand_pending c=%0d: got %b expected %b",
                           c, bus.exceptionPending, (!mact && elig != 16'h0));
      end
      checks++;
      if (bus.pendingBits !== mpend) begin
        errors++; $display("FAIL rand_bits c=%0d: got %h expected %h", c, bus.pendingBits, mpend);
      end
      checks++;
      if ({bus.inException, bus.cause, bus.vectorAddress} !== {mact, mcause, mvec}) begin
        errors++; $display("FAIL rand_state c=%0d: got inExc=%b cause=%0d vec=%h expected %b %0d %h",
                           c, bus.inException, bus.cause, bus.vectorAddress, mact, mcause, mvec);
      end
      @(posedge clk);
      if (!mact && elig != 16'h0 && bus.exceptionAck) begin
        w = -1;
        for (int i = 0; i < 16; i++) if (elig[i] && w < 0) w = i;
        mcause   = 5'(w);
        mvec     = bus.isrBaseAddress + 32'(w * 4);
        mpend[w] = 1'b0;
        mact     = 1'b1;
      end else if (mact && bus.exceptionReturn) begin
        mact = 1'b0;
      end
      setv  = {h1 & ~h2, bus.exceptionRequest[7:0]};
      h2    = h1;
      h1    = h0;
      h0    = bus.irq;
      mpend = mpend | setv;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_dispatch();
    test_irq_gating();
    test_priority();
    test_masking();
    test_same_cycle();
    test_reset_in_active();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports `clk` and `reset`.
REQ-002 Port list, as name, direction, width, meaning:
- `clk`  in  1  system clock.
- `reset`  in  1  async active-high reset.
- `exceptionRequest`  in  16  internal exception pulses; bits 7:0 used, bits 15:8 ignored.
- `irq`  in  8  external interrupt levels, asynchronous to `clk`.
- `interruptEnable`  in  1  global external-interrupt enable, from the system register block.
- `exceptionMask`  in  16  per-cause disable bits; 1 = disabled.
- `isrBaseAddress`  in  32  vector table base.
- `exceptionAck`  in  1  core accepts the exception at an instruction boundary.
- `exceptionReturn`  in  1  core executes return-from-exception.
- `exceptionPending`  out  1  an unmasked exception is awaiting ack.
- `cause`  out  5  captured cause number.
- `vectorAddress`  out  32  handler address.
- `inException`  out  1  handler active.
- `pendingBits`  out  16  raw pending register, for debug.

Function
REQ-003 SHALL pass each `irq[i]` through a 2-flop synchronizer, then detect rising edges; an edge sets pending bit 8+i.
REQ-004 SHALL set pending bit i (i = 0..7) when `exceptionRequest[i]` is high on a clock edge.
REQ-005 Pending bits SHALL be sticky until acknowledged. Latency: request in cycle N gives pending visible in N+1; `irq` edge gives pending in N+3.
REQ-006 A pending bit SHALL be eligible when:
- its `exceptionMask` bit is 0, and
- for bits 15:8 only, `interruptEnable` is 1.
REQ-007 Priority SHALL be fixed: lowest eligible index wins.
REQ-008 `exceptionPending` SHALL be combinational: (state == IDLE) AND (any eligible bit).
REQ-009 State machine SHALL have two states, IDLE and ACTIVE; reset state is IDLE.
REQ-010 In IDLE with `exceptionPending` = 1 and `exceptionAck` = 1, on the clock edge the block SHALL:
- register `cause` = {1'b0, winning index};
- register `vectorAddress` = `isrBaseAddress` + (index × 4), modulo 2^32;
- clear the winning pending bit;
- move to ACTIVE.
REQ-011 `exceptionAck` SHALL be ignored in ACTIVE, and ignored in IDLE when no bit is eligible.
REQ-012 `exceptionReturn` in ACTIVE SHALL move to IDLE on the next edge; it SHALL be ignored in IDLE.
REQ-013 In ACTIVE, new requests SHALL still set pending bits; no nesting; `exceptionPending` SHALL stay 0.
REQ-014 If a new request sets the bit being cleared by ack in the same cycle, the set SHALL win and the bit stays pending.
REQ-015 `inException` SHALL be 1 exactly when state == ACTIVE.
REQ-016 `cause` and `vectorAddress` SHALL hold their values until the next accepted ack.
REQ-017 Mask or enable changes SHALL never clear pending bits; they only gate eligibility.

Reset
REQ-018 On `reset`, the block SHALL:
- set state to IDLE;
- clear all pending bits and synchronizer/edge flops to 0;
- set `cause` = 0 and `vectorAddress` = 32'd4;
- drive `inException` = 0 and `exceptionPending` = 0.
REQ-019 Reset asserted while in ACTIVE SHALL abandon the handler immediately (asynchronously) with no residual pending state.
REQ-020 An `irq` line held high through reset release SHALL NOT generate an edge.

Structure
REQ-021 Shared package `exceptionGroup` SHALL hold:
- the state enum {IDLE, ACTIVE};
- constants `NUM_SOURCES` = 16, `IRQ_BASE` = 8, `VECTOR_STRIDE` = 4.
REQ-022 Sub-module `irq_sync` SHALL implement the per-line 2-flop synchronizer and rising-edge detector, parameterized by width.

Verification
REQ-023 Directed scenarios:
- Basic dispatch: `isrBaseAddress` = 0x100, `exceptionRequest[3]` pulse, ack → `cause` = 3, `vectorAddress` = 0x10C, `inException` = 1.
- Interrupt gating: `irq[1]` rises with `interruptEnable` = 0 → no `exceptionPending`. Set enable → pending; ack → `cause` = 9, `vectorAddress` = 0x124.
- Priority: bits 2 and 5 requested together → first ack gives `cause` 2. Return, then second ack gives `cause` 5.
- Masking: `exceptionMask[4]` = 1 with request 4 → `exceptionPending` = 0 but `pendingBits[4]` = 1. Clear the mask → `exceptionPending` = 1.
- Same-cycle set and clear: request bit 0 in the same cycle as the ack of bit 0 → after the edge, `pendingBits[0]` = 1 and state is ACTIVE.
- Reset in ACTIVE: assert `reset` → `inException` = 0, `pendingBits` = 0, `vectorAddress` = 4. An `irq` held high across reset gives no pending.
